sha256_compress_core: RTL and testbench
=======================================

SHA256_COMPRESS_CORE -- requirements
Module: sha256_compress_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 64, number of compression rounds; legal 1..64, values below 64 for bench shortening only.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to compress one block; sampled only in IDLE.
REQ-005 SHALL have port in_hash  input  256  chaining value H0..H7; H0 in [255:224], H7 in [31:0].
REQ-006 SHALL have port in_W  input  32  message-schedule word W[t] for the round shown on out_round, valid combinationally same cycle.
REQ-007 SHALL have port in_K  input  32  round constant K[t] for the round shown on out_round, valid combinationally same cycle.
REQ-008 SHALL have port out_round  output  6  current round index t; 0 outside ROUND.
REQ-009 SHALL have port busy  output  1  high while in ROUND or ADD.
REQ-010 SHALL have port done  output  1  one-cycle pulse, out_hash valid.
REQ-011 SHALL have port out_hash  output  256  updated chaining value, same packing as in_hash.

Function
REQ-012 SHALL implement FSM states IDLE, ROUND, ADD; encoding free.
REQ-013 IDLE with start=1 at edge N: SHALL load A..H from in_hash, store in_hash copy, round counter=0, go to ROUND.
REQ-014 ROUND, each edge: SHALL compute T1 = H + Sigma1(E) + Ch(E,F,G) + in_K + in_W; T2 = Sigma0(A) + Maj(A,B,C); all additions mod 2^32.
REQ-015 ROUND update SHALL be H<=G, G<=F, F<=E, E<=D+T1, D<=C, C<=B, B<=A, A<=T1+T2.
REQ-016 Sigma0 = ROTR2^ROTR13^ROTR22; Sigma1 = ROTR6^ROTR11^ROTR25; Ch = (E&F)^(~E&G); Maj = (A&B)^(A&C)^(B&C); the existing sigma/Ch/Ma/T2 function blocks SHALL be reused.
REQ-017 Round counter SHALL increment each ROUND edge; on edge with counter=ROUNDS-1 SHALL go to ADD; no wrap past ROUNDS-1.
REQ-018 ADD edge: SHALL register out_hash word i = stored in_hash word i + working register i (mod 2^32), assert done, return to IDLE.
REQ-019 Latency: start sampled at edge N -> ROUND edges N+1..N+ROUNDS -> done high for the cycle after edge N+ROUNDS+1 (65 for ROUNDS=64).
REQ-020 done SHALL be high exactly one cycle per accepted start; deasserts on next edge.
REQ-021 out_hash SHALL hold its value until the next ADD edge; SHALL NOT change during ROUND.
REQ-022 start while busy SHALL be ignored, no queueing; start in the done cycle SHALL be accepted (back-to-back blocks, state IDLE).
REQ-023 in_hash SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the result.
REQ-024 busy SHALL be high from edge N through edge N+ROUNDS+1 exclusive of the done cycle.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, counter 0, A..H 0, stored hash 0, out_hash 0, done 0, busy 0, out_round 0.
REQ-026 rst asserted mid-ROUND or ADD SHALL abort the block with no done pulse; first start after rst release SHALL complete normally.
REQ-027 start high during rst SHALL be ignored; start sampled on first edge with rst=0.

Verification
REQ-028 "abc" single block: in_hash = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, W/K from standard schedule -> done at edge N+65, out_hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-029 Empty message, same in_hash -> out_hash = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-030 start pulsed at round 10 of a running block -> ignored; single done, result unchanged from REQ-028.
REQ-031 rst asserted at round 30 -> all outputs 0 at once, no done; subsequent "abc" run -> REQ-028 result.
REQ-032 start held high continuously over two blocks -> second block accepted in first block's done cycle; two done pulses 66 cycles apart, both correct.
REQ-033 in_hash changed to all-ones after the accepting edge -> result identical to REQ-028.

Source files
------------

// File: rtl/sha256_compress_core.sv
// SHA-256 compression core: one round per clock over an externally supplied W/K stream,
// followed by a single feed-forward add into the chaining value.
module sha256_compress_core #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] in_hash,
  input  logic [31:0]  in_W,
  input  logic [31:0]  in_K,
  output logic [5:0]   out_round,
  output logic         busy,
  output logic         done,
  output logic [255:0] out_hash
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_ADD   = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Working registers share the in_hash packing: lane 7 is A, lane 0 is H.
  state_t            state_q, state_d;
  logic [7:0][31:0]  wr_q, wr_d;
  logic [7:0][31:0]  hash_in_q, hash_in_d;
  logic [7:0][31:0]  out_hash_q, out_hash_d;
  logic [5:0]        round_q, round_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       t1_s, t2_s;

  // Next-state, round datapath and feed-forward add.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    hash_in_d  = hash_in_q;
    out_hash_d = out_hash_q;
    round_d    = round_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    t1_s = wr_q[0] + big_sigma1(wr_q[3]) + ch(wr_q[3], wr_q[2], wr_q[1]) + in_K + in_W;
    t2_s = big_sigma0(wr_q[7]) + maj(wr_q[7], wr_q[6], wr_q[5]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_d      = in_hash;
          hash_in_d = in_hash;
          round_d   = 6'd0;
          busy_d    = 1'b1;
          state_d   = S_ROUND;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ROUND: begin
        wr_d = {t1_s + t2_s, wr_q[7], wr_q[6], wr_q[5],
                wr_q[4] + t1_s, wr_q[3], wr_q[2], wr_q[1]};
        if (round_q == LAST_ROUND) begin
          round_d = 6'd0;
          state_d = S_ADD;
        end else begin
          round_d = round_q + 6'd1;
        end
      end
      S_ADD: begin
        for (int i = 0; i < 8; i++) begin
          out_hash_d[i] = hash_in_q[i] + wr_q[i];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        round_d = 6'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, aborting any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      hash_in_q  <= '0;
      out_hash_q <= '0;
      round_q    <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      hash_in_q  <= hash_in_d;
      out_hash_q <= out_hash_d;
      round_q    <= round_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out_round = round_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_hash  = out_hash_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Scoreboard bench for sha256_compress_core: a software SHA-256 model supplies expectations,
// a negedge monitor checks every done pulse and out_hash stability.
module tb_sha256_compress_core;

  localparam int ROUNDS = 64;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H_INIT    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_HASH  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_HASH = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

  logic         clk, rst, start;
  logic [255:0] in_hash;
  logic [31:0]  in_W, in_K;
  logic [5:0]   out_round;
  logic         busy, done;
  logic [255:0] out_hash;

  logic [31:0]  cur_w [64];

  typedef struct {
    logic [255:0] hash;
    int           acc;
  } exp_t;

  exp_t         sb_q [$];
  logic [255:0] model_out;
  int           cyc;
  int           checks;
  int           errors;

  sha256_compress_core #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .start(start), .in_hash(in_hash), .in_W(in_W), .in_K(in_K),
    .out_round(out_round), .busy(busy), .done(done), .out_hash(out_hash)
  );

  assign in_W = cur_w[out_round];
  assign in_K = K_TAB[out_round];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Standard message expansion into the schedule the DUT reads through out_round.
  task automatic load_block(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) cur_w[t] = blk[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++) begin
      cur_w[t] = (rotr(cur_w[t-2], 17) ^ rotr(cur_w[t-2], 19) ^ (cur_w[t-2] >> 10))
               + cur_w[t-7]
               + (rotr(cur_w[t-15], 7) ^ rotr(cur_w[t-15], 18) ^ (cur_w[t-15] >> 3))
               + cur_w[t-16];
    end
  endtask

  function automatic logic [255:0] ref_compress(input logic [255:0] h);
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = h[255 - 32 * i -: 32];
    for (int t = 0; t < ROUNDS; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + cur_w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = h[255 - 32 * i -: 32] + v[i];
    return r;
  endfunction

  // Monitor: pops an expectation on every done, otherwise out_hash must hold the last result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done at cycle %0d", cyc);
          end else begin
            e = sb_q.pop_front();
            if (out_hash !== e.hash) begin
              errors++;
              $display("FAIL out_hash got %h want %h", out_hash, e.hash);
            end
            checks++;
            if (cyc - e.acc != ROUNDS + 1) begin
              errors++;
              $display("FAIL latency got %0d want %0d", cyc - e.acc, ROUNDS + 1);
            end
            checks++;
            if (busy !== 1'b0) begin
              errors++;
              $display("FAIL busy_in_done got %b want 0", busy);
            end
            model_out = e.hash;
          end
        end else begin
          checks++;
          if (out_hash !== model_out) begin
            errors++;
            $display("FAIL out_hash_hold got %h want %h", out_hash, model_out);
          end
        end
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    checks++;
    if (out_hash !== 256'h0 || done !== 1'b0 || busy !== 1'b0 || out_round !== 6'd0) begin
      errors++;
      $display("FAIL %s got hash=%h done=%b busy=%b round=%0d want all zero",
               tag, out_hash, done, busy, out_round);
    end
  endtask

  // Called at a negedge with start already driven high; returns one negedge after the accepting edge.
  task automatic accept(input logic [255:0] exp_hash, input bit keep_start);
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    sb_q.push_back('{exp_hash, cyc});
    checks++;
    if (busy !== 1'b1 || out_round !== 6'd0) begin
      errors++;
      $display("FAIL accept got busy=%b round=%0d want busy=1 round=0", busy, out_round);
    end
  endtask

  task automatic issue(input logic [255:0] h, input logic [255:0] exp_hash);
    in_hash = h;
    start   = 1'b1;
    accept(exp_hash, 1'b0);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < ROUNDS + 10; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got no done want done within %0d cycles", ROUNDS + 10);
    end
  endtask

  task automatic wait_round(input logic [5:0] r);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < ROUNDS + 4; i++) begin
      @(negedge clk);
      if (out_round == r) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL round_timeout got no round %0d want it reached", r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk;
    logic [255:0] h, e;
    checks    = 0;
    errors    = 0;
    model_out = '0;
    rst       = 1'b1;
    start     = 1'b0;
    in_hash   = '0;
    for (int t = 0; t < 64; t++) cur_w[t] = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Known-answer blocks
    load_block(ABC_BLK);
    issue(H_INIT, ABC_HASH);
    wait_done();
    load_block(EMPTY_BLK);
    issue(H_INIT, EMPTY_HASH);
    wait_done();

    // Start pulsed mid-block must be ignored
    load_block(ABC_BLK);
    issue(H_INIT, ABC_HASH);
    wait_round(6'd10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (ROUNDS + 6) @(negedge clk);

    // in_hash changes after the accepting edge have no effect
    load_block(ABC_BLK);
    issue(H_INIT, ABC_HASH);
    in_hash = {256{1'b1}};
    wait_done();

    // Reset mid-block aborts; start held through reset is taken on the first free edge
    load_block(ABC_BLK);
    issue(H_INIT, ABC_HASH);
    wait_round(6'd30);
    #2;
    rst   = 1'b1;
    start = 1'b1;
    in_hash = H_INIT;
    sb_q.delete();
    model_out = '0;
    #1;
    check_idle_zero("reset_abort");
    repeat (3) @(negedge clk);
    check_idle_zero("reset_hold");
    rst = 1'b0;
    accept(ABC_HASH, 1'b0);
    wait_done();

    // Back-to-back with start held high across two blocks
    load_block(ABC_BLK);
    in_hash = H_INIT;
    start   = 1'b1;
    accept(ABC_HASH, 1'b1);
    wait_done();
    load_block(EMPTY_BLK);
    sb_q.push_back('{EMPTY_HASH, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Random blocks and chaining values against the reference model
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) blk[i * 32 +: 32] = $urandom();
      for (int i = 0; i < 8; i++) h[i * 32 +: 32] = $urandom();
      load_block(blk);
      e = ref_compress(h);
      issue(h, e);
      wait_done();
    end

    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
